// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store controller: FSM states, funct3
// size codes, byte-enable and lane-replication helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } lsu_state_e;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Codes 011, 110 and 111 fall through to word accesses.
    function automatic logic is_byte(input logic [2:0] sz);
        return (sz[1:0] == 2'b00);
    endfunction

    function automatic logic is_half(input logic [2:0] sz);
        return (sz[1:0] == 2'b01);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] sz, input logic [1:0] off);
        if (is_byte(sz))
            return 1'b0;
        else if (is_half(sz))
            return off[0];
        else
            return (off != 2'b00);
    endfunction

    // Lane offset actually used: misaligned low bits are dropped.
    function automatic logic [1:0] eff_offset(input logic [2:0] sz, input logic [1:0] off);
        if (is_byte(sz))
            return off;
        else if (is_half(sz))
            return {off[1], 1'b0};
        else
            return 2'b00;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] sz, input logic [1:0] off);
        if (is_byte(sz))
            return 4'b0001 << off;
        else if (is_half(sz))
            return 4'b0011 << off;
        else
            return 4'b1111;
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] sz, input logic [31:0] wd);
        if (is_byte(sz))
            return {4{wd[7:0]}};
        else if (is_half(sz))
            return {2{wd[15:0]}};
        else
            return wd;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load alignment: shifts the addressed lane down to bit 0 and
// sign/zero-extends it according to the funct3 size code.
module load_align_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] ext_data
);

    logic [31:0] w_shifted;

    assign w_shifted = rdata >> {offset, 3'b000};

    always_comb begin
        ext_data = w_shifted;
        case (size)
            SZ_B:    ext_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_BU:   ext_data = {24'h000000, w_shifted[7:0]};
            SZ_H:    ext_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            SZ_HU:   ext_data = {16'h0000, w_shifted[15:0]};
            default: ext_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the core memory stage and a req/gnt/rvalid
// data-memory port. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_req,
    input  logic          st_req,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic [2:0]    size,
    output logic          lsu_stall,
    output logic [DW-1:0] ld_data,
    output logic          done,
    output logic          misalign_exc,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    lsu_state_e    r_state;
    logic          r_is_ld;
    logic [2:0]    r_size;
    logic [1:0]    r_off;
    logic [DW-1:0] r_ld_data;
    logic          r_done;
    logic          r_misalign;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [3:0]    r_mem_be;

    logic          w_req_any;
    logic          w_trap;
    logic [1:0]    w_off;
    logic [31:0]   w_ext;

    assign w_req_any = ld_req | st_req;
    assign w_off     = eff_offset(size, addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(size, addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    load_align_ext u_align (
        .rdata    (mem_rdata),
        .offset   (r_off),
        .size     (r_size),
        .ext_data (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_is_ld     <= 1'b0;
            r_size      <= SZ_W;
            r_off       <= 2'b00;
            r_ld_data   <= '0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= 4'b0000;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        assert (!(ld_req && st_req))
                            else $warning("lsu_ctrl: ld_req and st_req both high, store dropped");
                        // Load wins when both are raised.
                        r_is_ld     <= ld_req;
                        r_size      <= size;
                        r_off       <= w_off;
                        r_mem_we    <= ~ld_req;
                        r_mem_addr  <= {addr[AW-1:2], 2'b00};
                        r_mem_be    <= byte_en(size, w_off);
                        r_mem_wdata <= replicate(size, wdata);
                        if (w_trap) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_misalign <= 1'b1;
                            r_ld_data  <= '0;
                        end else begin
                            r_state   <= REQ;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (r_is_ld) begin
                            r_state <= WAIT_R;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        r_ld_data <= w_ext;
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign lsu_stall    = ((r_state == IDLE) && w_req_any) || (r_state == REQ) || (r_state == WAIT_R);
    assign ld_data      = r_ld_data;
    assign done         = r_done;
    assign misalign_exc = r_misalign;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_be       = r_mem_be;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected memory requests and
// completions into queues; monitors pop and compare when the DUT presents them.
module tb_lsu_ctrl;
    import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req, st_req;
    logic [31:0] addr, wdata;
    logic [2:0]  size;
    logic        lsu_stall, done, misalign_exc;
    logic [31:0] ld_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_req       (ld_req),
        .st_req       (st_req),
        .addr         (addr),
        .wdata        (wdata),
        .size         (size),
        .lsu_stall    (lsu_stall),
        .ld_data      (ld_data),
        .done         (done),
        .misalign_exc (misalign_exc),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        string       name;
    } req_t;

    typedef struct {
        logic [31:0] ld;
        logic        exc;
        string       name;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int    errors = 0;
    int    checks = 0;
    logic [31:0] last_ld = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Request monitor: every cycle mem_req is high it must match the head entry.
    always @(negedge clk) begin
        req_t e;
        if (mem_req === 1'b1) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got mem_req at addr %h, expected none", mem_addr);
            end else begin
                e = req_q[0];
                check32({e.name, "_we"},    32'(mem_we),    32'(e.we));
                check32({e.name, "_addr"},  mem_addr,       e.addr);
                check32({e.name, "_be"},    32'(mem_be),    32'(e.be));
                check32({e.name, "_wdata"}, mem_wdata,      e.wdata);
                if (mem_gnt === 1'b1) begin
                    void'(req_q.pop_front());
                    $display("req  %s: we=%b addr=%h be=%b wdata=%h", e.name, mem_we, mem_addr, mem_be, mem_wdata);
                end
            end
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        done_t d;
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with ld_data %h, expected no completion", ld_data);
            end else begin
                d = done_q.pop_front();
                check32({d.name, "_ld_data"}, ld_data, d.ld);
                check32({d.name, "_misalign_exc"}, 32'(misalign_exc), 32'(d.exc));
                $display("done %s: ld_data=%h misalign_exc=%b", d.name, ld_data, misalign_exc);
            end
        end
    end

    task automatic run_txn(input string name, input bit l, input bit s,
                           input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sz,
                           input int gdly, input int rdly, input logic [31:0] rd,
                           input logic [3:0] e_be, input logic [31:0] e_maddr,
                           input logic [31:0] e_mwd, input logic [31:0] e_ld,
                           input bit trap, input int e_done_cyc);
        req_t  r;
        done_t d;
        bit    granted   = 1'b0;
        int    gcnt      = 0;
        int    gcyc      = -1;
        int    done_cyc  = -1;
        int    stall_bad = 0;
        if (!trap) begin
            r.we    = s && !l;
            r.addr  = e_maddr;
            r.be    = e_be;
            r.wdata = e_mwd;
            r.name  = name;
            req_q.push_back(r);
        end
        d.ld   = (l || trap) ? e_ld : last_ld;
        d.exc  = trap;
        d.name = name;
        done_q.push_back(d);
        if (l || trap)
            last_ld = e_ld;
        ld_req = l;
        st_req = s;
        addr   = a;
        wdata  = wd;
        size   = sz;
        for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (mem_req && !granted) begin
                if (gcnt == gdly) begin
                    mem_gnt = 1'b1;
                    granted = 1'b1;
                    gcyc    = cyc;
                end
                gcnt++;
            end else if (granted && l && cyc == gcyc + rdly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end
            @(negedge clk);
            if (lsu_stall !== (done === 1'b1 ? 1'b0 : 1'b1))
                stall_bad++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                ld_req   = 1'b0;
                st_req   = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        ld_req     = 1'b0;
        st_req     = 1'b0;
        check32({name, "_done_cycle"}, 32'(done_cyc), 32'(e_done_cyc));
        check32({name, "_stall_mismatch_cycles"}, 32'(stall_bad), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ld_req = 1'b0; st_req = 1'b0;
        addr = '0; wdata = '0; size = SZ_W;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst_stall",     32'(lsu_stall),    32'd0);
        check32("rst_done",      32'(done),         32'd0);
        check32("rst_misalign",  32'(misalign_exc), 32'd0);
        check32("rst_mem_req",   32'(mem_req),      32'd0);
        check32("rst_mem_we",    32'(mem_we),       32'd0);
        check32("rst_mem_be",    32'(mem_be),       32'd0);
        check32("rst_ld_data",   ld_data,           32'h0);
        check32("rst_mem_addr",  mem_addr,          32'h0);
        check32("rst_mem_wdata", mem_wdata,         32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //       name     l  s  addr          wdata         size   g  r  rdata         be       maddr         mwdata        ld_data       trap done
        run_txn("lb_103", 1, 0, 32'h103, 32'h0,        SZ_B,  1, 1, 32'h80AABBCC, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80, 0, 4);
        run_txn("lhu_102",1, 0, 32'h102, 32'h0,        SZ_HU, 0, 1, 32'h92345678, 4'b1100, 32'h100, 32'h0,        32'h00009234, 0, 3);
        run_txn("sb_101", 0, 1, 32'h101, 32'h000000A5, SZ_B,  2, 1, 32'h0,        4'b0010, 32'h100, 32'hA5A5A5A5, 32'h0,        0, 4);
        run_txn("lw_206", 1, 0, 32'h206, 32'h0,        SZ_W,  0, 1, 32'h11223344, 4'b1111, 32'h204, 32'h0,
                TRAP_EN ? 32'h0 : 32'h11223344, TRAP_EN, TRAP_EN ? 1 : 3);
        run_txn("lh_102", 1, 0, 32'h102, 32'h0,        SZ_H,  0, 2, 32'h80010000, 4'b1100, 32'h100, 32'h0,        32'hFFFF8001, 0, 4);
        run_txn("sh_202", 0, 1, 32'h202, 32'hFFFF1234, SZ_H,  0, 1, 32'h0,        4'b1100, 32'h200, 32'h12341234, 32'h0,        0, 2);
        run_txn("sw_010", 0, 1, 32'h010, 32'hDEADBEEF, SZ_W,  1, 1, 32'h0,        4'b1111, 32'h010, 32'hDEADBEEF, 32'h0,        0, 3);
        run_txn("lbu_100",1, 0, 32'h100, 32'h0,        SZ_BU, 0, 1, 32'h123456FF, 4'b0001, 32'h100, 32'h0,        32'h000000FF, 0, 3);
        run_txn("lh_101", 1, 0, 32'h101, 32'h0,        SZ_H,  0, 1, 32'h0000F00D, 4'b0011, 32'h100, 32'h0,
                TRAP_EN ? 32'h0 : 32'hFFFFF00D, TRAP_EN, TRAP_EN ? 1 : 3);
        run_txn("l011_008",1,0, 32'h008, 32'h0,        3'b011,0, 1, 32'h87654321, 4'b1111, 32'h008, 32'h0,        32'h87654321, 0, 3);
        run_txn("lb_102", 1, 0, 32'h102, 32'h0,        SZ_B,  0, 1, 32'h00C30000, 4'b0100, 32'h100, 32'h0,        32'hFFFFFFC3, 0, 3);

        // Reset while waiting for read data; the late rvalid must be ignored.
        begin
            req_t r;
            r.we = 1'b0; r.addr = 32'h400; r.be = 4'b1111; r.wdata = 32'h0; r.name = "lw_rst";
            req_q.push_back(r);
            ld_req = 1'b1; addr = 32'h400; size = SZ_W; wdata = 32'h0;
            @(posedge clk); #1;
            mem_gnt = 1'b1;
            @(posedge clk); #1;
            mem_gnt = 1'b0; ld_req = 1'b0; rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
            @(negedge clk);
            check32("lw_rst_stall",   32'(lsu_stall), 32'd0);
            check32("lw_rst_mem_req", 32'(mem_req),   32'd0);
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            repeat (3) @(negedge clk);
            check32("lw_rst_ld_data", ld_data,        32'h0);
            check32("lw_rst_done",    32'(done),      32'd0);
            last_ld = 32'h0;
            $display("txn  lw_rst: reset in WAIT_R, late rvalid ignored");
            @(posedge clk); #1;
        end

        run_txn("ldst_300", 1, 1, 32'h300, 32'h5555AAAA, SZ_W, 0, 1, 32'h0BADCAFE, 4'b1111, 32'h300, 32'h5555AAAA, 32'h0BADCAFE, 0, 3);

        repeat (3) @(posedge clk);
        check32("req_queue_drained",  32'(req_q.size()),  32'd0);
        check32("done_queue_drained", 32'(done_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
